count_game_ctrl: RTL and testbench
==================================

// Module: count_game_ctrl
// PURPOSE
//  Round controller directly upstream of the countdown counter in count_game.
//  - Debounces the start and hit keys.
//  - Selects and holds the countdown value num; drives the counter's active-low clear cst and display enable dzst.
//  - Consumes the counter's over flag.
//  - Player wins a round by pressing hit before over rises; tracks score across a game of ROUNDS rounds.
// PARAMETERS
//  DEB_CYC   20  cycles a raw key must be stable before a debounced edge is accepted (20 ms at 1 kHz clk)
//  ARM_CYC   2   cycles cst is held low in ARM before the countdown starts (>=1)
//  ROUNDS    5   rounds per game (1..15)
//  SCORE_MAX 9   score saturation value (<=15)
// PORTS
//  clk       in   1  system clock, same 1 kHz clock as the counter; single clock domain
//  rst       in   1  synchronous, active-high reset
//  btn_start in   1  raw start key, active high, asynchronous; synchronised by 2 flops internally
//  btn_hit   in   1  raw player key, active high, asynchronous; synchronised by 2 flops internally
//  sw_num    in   3  preset countdown value from switches
//  over      in   1  counter timeout flag; level, held until the next cst low
//  num       out  3  countdown value to the counter; registered, never 0
//  cst       out  1  counter clear, active low; registered
//  dzst      out  1  dot-matrix display enable; registered
//  score     out  4  rounds won in the current game
//  round_no  out  4  rounds completed in the current game
//  win       out  1  high in RESULT when the last round was won
//  lose      out  1  high in RESULT when the last round was lost
//  game_done out  1  high in DONE
// BEHAVIOUR
//  Reset values (next edge with rst=1): state=IDLE, num=1, cst=0, dzst=0, score=0, round_no=0, win=lose=game_done=0, debouncers cleared.
//  - Reset mid-round behaves the same; cst=0 also clears the counter.
//  Debounce:
//  - Press pulse = 1-cycle pulse when the synchronised key has been 1 for DEB_CYC consecutive cycles after having been 0.
//  - Holding the key gives one pulse only.
//  FSM: IDLE -> ARM -> RUN -> RESULT -> (ARM | DONE); DONE -> ARM.
//  - IDLE: cst=0, dzst=0. start pulse -> ARM.
//  - ARM (entry): latch num (see CONFIGURATION); clear win/lose.
//    - cst=0, dzst=1 for ARM_CYC cycles, then RUN.
//    - hit ignored.
//  - RUN: cst=1, dzst=1; num stable throughout.
//    - over=1 -> RESULT, lose=1.
//    - else hit pulse -> RESULT, win=1, score+1 saturating at SCORE_MAX.
//    - hit and over in the same cycle: over wins (lose).
//    - start pulses ignored.
//  - RESULT: cst stays 1 so the counter shows its frozen value; round_no incremented on entry.
//    - If round_no reaches ROUNDS -> DONE (next cycle).
//    - Else start pulse -> ARM.
//  - DONE: game_done=1, cst=1, dzst=1; score and round_no held.
//    - start pulse -> ARM, with score=0 and round_no=0 on the same edge.
//  Latency: start pulse to cst low = 1 cycle; RUN to RESULT = 1 cycle after the over/hit pulse.
//  All outputs are registered; no combinational path from input to output.
// CONFIGURATION
//  RAND_NUM_EN
//  - Defined: a 3-bit LFSR (x^3+x^2+1, seed 3'b001, steps every cycle, never 0) runs.
//    - sw_num==0 -> num latches the LFSR value.
//    - Otherwise num = sw_num.
//  - Undefined: no LFSR.
//    - num = sw_num, with sw_num==0 mapped to 1.
// TESTING
//  1. Reset: rst high for 3 cycles -> cst=0, dzst=0, num=1, score=0, state IDLE.
//  2. sw_num=3, start held 25 cycles -> one start pulse; cst=0 for 2 cycles then 1, num=3 throughout.
//     - Then over=1 -> lose=1, round_no=1, score=0.
//  3. In RUN, a 5-cycle hit glitch -> no pulse, stays RUN.
//     - A 25-cycle hit -> win=1, score=1; a further hit in RESULT has no effect.
//  4. Same-cycle hit pulse and over=1 in RUN -> lose=1, score unchanged.
//  5. Five rounds all won -> score=5, round_no=5, game_done=1.
//     - Then start -> score=0, round_no=0, state ARM.
//  6. rst asserted during RUN -> next cycle cst=0, IDLE, score=0.
//     - With RAND_NUM_EN and sw_num=0: num in 1..7 across rounds.

Source files
------------

// File: rtl/count_game_ctrl.sv
// Round controller for count_game: key debounce, countdown value selection, counter clear/enable, scoring.
// Optional RAND_NUM_EN: sw_num==0 picks a pseudo-random countdown value from a 3-bit LFSR.

module count_game_deb #(
   parameter int DEB_CYC = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key,
   output logic o_pulse
);
   localparam int CW = $clog2(DEB_CYC + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_pulse;

   // r_cnt saturates at DEB_CYC so a held key yields a single pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_key};
         if (!r_sync[1]) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
         end else if (r_cnt < CW'(DEB_CYC)) begin
            r_cnt   <= r_cnt + 1'b1;
            r_pulse <= (r_cnt == CW'(DEB_CYC - 1));
         end else begin
            r_pulse <= 1'b0;
         end
      end
   end

   assign o_pulse = r_pulse;
endmodule

module count_game_ctrl #(
   parameter int DEB_CYC   = 20,
   parameter int ARM_CYC   = 2,
   parameter int ROUNDS    = 5,
   parameter int SCORE_MAX = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_hit,
   input  logic [2:0] sw_num,
   input  logic       over,
   output logic [2:0] num,
   output logic       cst,
   output logic       dzst,
   output logic [3:0] score,
   output logic [3:0] round_no,
   output logic       win,
   output logic       lose,
   output logic       game_done
);
   typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_RESULT, S_DONE} state_t;

   localparam int AW = $clog2(ARM_CYC + 1);

   state_t        r_state;
   logic [2:0]    r_num;
   logic          r_cst;
   logic          r_dzst;
   logic [3:0]    r_score;
   logic [3:0]    r_round;
   logic          r_win;
   logic          r_lose;
   logic          r_done;
   logic [AW-1:0] r_arm_cnt;

   logic [2:0]    w_num_sel;
   logic          w_start_p;
   logic          w_hit_p;
   logic          w_last_round;
   logic          w_go_arm;

   count_game_deb #(.DEB_CYC(DEB_CYC)) u_deb_start (
      .clk     (clk),
      .rst     (rst),
      .i_key   (btn_start),
      .o_pulse (w_start_p)
   );

   count_game_deb #(.DEB_CYC(DEB_CYC)) u_deb_hit (
      .clk     (clk),
      .rst     (rst),
      .i_key   (btn_hit),
      .o_pulse (w_hit_p)
   );

`ifdef RAND_NUM_EN
   logic [2:0] r_lfsr;

   // x^3+x^2+1 cycles through all seven non-zero values
   always_ff @(posedge clk) begin
      if (rst) r_lfsr <= 3'b001;
      else     r_lfsr <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
   end

   assign w_num_sel = (sw_num == 3'd0) ? r_lfsr : sw_num;
`else
   assign w_num_sel = (sw_num == 3'd0) ? 3'd1 : sw_num;
`endif

   assign w_last_round = (r_round == 4'(ROUNDS));
   assign w_go_arm     = w_start_p && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                       ((r_state == S_RESULT) && !w_last_round));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_num     <= 3'd1;
         r_cst     <= 1'b0;
         r_dzst    <= 1'b0;
         r_score   <= '0;
         r_round   <= '0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
         r_done    <= 1'b0;
         r_arm_cnt <= '0;
      end else if (w_go_arm) begin
         r_state   <= S_ARM;
         r_num     <= w_num_sel;
         r_cst     <= 1'b0;
         r_dzst    <= 1'b1;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
         r_done    <= 1'b0;
         r_arm_cnt <= AW'(1);
         if (r_state == S_DONE) begin
            r_score <= '0;
            r_round <= '0;
         end
      end else begin
         case (r_state)
            S_ARM: begin
               if (r_arm_cnt == AW'(ARM_CYC)) begin
                  r_state <= S_RUN;
                  r_cst   <= 1'b1;
               end else begin
                  r_arm_cnt <= r_arm_cnt + 1'b1;
               end
            end
            S_RUN: begin
               // a timeout in the same cycle as a hit counts as a loss
               if (over) begin
                  r_state <= S_RESULT;
                  r_lose  <= 1'b1;
                  r_round <= r_round + 4'd1;
               end else if (w_hit_p) begin
                  r_state <= S_RESULT;
                  r_win   <= 1'b1;
                  r_round <= r_round + 4'd1;
                  if (r_score < 4'(SCORE_MAX)) r_score <= r_score + 4'd1;
               end
            end
            S_RESULT: begin
               if (w_last_round) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_win   <= 1'b0;
                  r_lose  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign num       = r_num;
   assign cst       = r_cst;
   assign dzst      = r_dzst;
   assign score     = r_score;
   assign round_no  = r_round;
   assign win       = r_win;
   assign lose      = r_lose;
   assign game_done = r_done;
endmodule

// File: tb/tb_count_game_ctrl.sv
// Bench for count_game_ctrl: directed rounds plus random key/over/reset traffic against a round-level model.
module tb_count_game_ctrl;
   localparam int DEB_CYC   = 20;
   localparam int ARM_CYC   = 2;
   localparam int ROUNDS    = 5;
   localparam int SCORE_MAX = 9;

   localparam int PH_IDLE = 0, PH_ARM = 1, PH_RUN = 2, PH_RES = 3, PH_DONE = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_hit = 1'b0;
   logic [2:0] sw_num = 3'd0;
   logic       over = 1'b0;
   logic [2:0] num;
   logic       cst, dzst, win, lose, game_done;
   logic [3:0] score, round_no;

   count_game_ctrl #(
      .DEB_CYC(DEB_CYC), .ARM_CYC(ARM_CYC), .ROUNDS(ROUNDS), .SCORE_MAX(SCORE_MAX)
   ) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_hit(btn_hit), .sw_num(sw_num),
      .over(over), .num(num), .cst(cst), .dzst(dzst), .score(score), .round_no(round_no),
      .win(win), .lose(lose), .game_done(game_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;
   int arm_low = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- round-level model ----------------
   int m_ph = PH_IDLE, m_arm_n = 0, m_score = 0, m_rounds = 0, m_num = 1;
   bit m_won = 0;
   int m_run_s = 0, m_run_h = 0;
   bit m_hs1 = 0, m_hs2 = 0, m_hh1 = 0, m_hh2 = 0;
   bit m_pstart = 0, m_phit = 0;
   logic [2:0] m_lfsr = 3'b001;

   function automatic int pick_num(input logic [2:0] sw, input logic [2:0] lf);
`ifdef RAND_NUM_EN
      return (sw == 3'd0) ? int'(lf) : int'(sw);
`else
      return (sw == 3'd0) ? 1 : int'(sw);
`endif
   endfunction

   always @(posedge clk) begin
      bit ds, dh;
      if (rst) begin
         m_ph = PH_IDLE; m_num = 1; m_score = 0; m_rounds = 0; m_won = 0; m_arm_n = 0;
         m_hs1 = 0; m_hs2 = 0; m_hh1 = 0; m_hh2 = 0; m_run_s = 0; m_run_h = 0;
         m_pstart = 0; m_phit = 0; m_lfsr = 3'b001;
      end else begin
         bit go;
         go = m_pstart && (m_ph == PH_IDLE || m_ph == PH_DONE || (m_ph == PH_RES && m_rounds != ROUNDS));
         if (go) begin
            if (m_ph == PH_DONE) begin m_score = 0; m_rounds = 0; end
            m_ph = PH_ARM; m_arm_n = 1; m_num = pick_num(sw_num, m_lfsr);
         end else if (m_ph == PH_ARM) begin
            if (m_arm_n == ARM_CYC) m_ph = PH_RUN; else m_arm_n++;
         end else if (m_ph == PH_RUN) begin
            if (over) begin m_won = 0; m_ph = PH_RES; m_rounds++; end
            else if (m_phit) begin
               m_won = 1; m_ph = PH_RES; m_rounds++;
               m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
            end
         end else if (m_ph == PH_RES && m_rounds == ROUNDS) begin
            m_ph = PH_DONE;
         end
         m_lfsr = {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
         // a key counts once its synchronised level has been high for exactly DEB_CYC cycles
         ds = m_hs2; m_hs2 = m_hs1; m_hs1 = btn_start;
         dh = m_hh2; m_hh2 = m_hh1; m_hh1 = btn_hit;
         m_run_s = ds ? m_run_s + 1 : 0;
         m_run_h = dh ? m_run_h + 1 : 0;
         m_pstart = ds && (m_run_s == DEB_CYC);
         m_phit   = dh && (m_run_h == DEB_CYC);
      end
   end

   always @(negedge clk) begin
      if (!cst && dzst) arm_low++;
      if (chk_en) begin
         chk("num",       8'(num),       8'(m_num));
         chk("cst",       8'(cst),       8'(m_ph == PH_RUN || m_ph == PH_RES || m_ph == PH_DONE));
         chk("dzst",      8'(dzst),      8'(m_ph != PH_IDLE));
         chk("score",     8'(score),     8'(m_score));
         chk("round_no",  8'(round_no),  8'(m_rounds));
         chk("win",       8'(win),       8'(m_ph == PH_RES && m_won));
         chk("lose",      8'(lose),      8'(m_ph == PH_RES && !m_won));
         chk("game_done", 8'(game_done), 8'(m_ph == PH_DONE));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start(input int hold);
      btn_start = 1'b1; cyc(hold); btn_start = 1'b0; cyc(3);
   endtask

   task automatic press_hit(input int hold);
      btn_hit = 1'b1; cyc(hold); btn_hit = 1'b0; cyc(3);
   endtask

   task automatic wait_run();
      bit found = 0;
      for (int k = 0; k < 200; k++) begin
         if (cst && dzst && !win && !lose && !game_done) begin found = 1; break; end
         @(negedge clk);
      end
      chk("wait_run_timeout", 8'(found), 8'd1);
   endtask

   task automatic win_round();
      press_start(25); wait_run(); press_hit(25);
   endtask

   // start pulse lands on the FSM 22 edges after the key rises; check ARM entry right after
   task automatic start_check();
      btn_start = 1'b1; cyc(23);
      chk("arm_score", 8'(score), 8'd0);
      chk("arm_round", 8'(round_no), 8'd0);
      chk("arm_cst", 8'(cst), 8'd0);
      chk("arm_dzst", 8'(dzst), 8'd1);
      chk("arm_done", 8'(game_done), 8'd0);
      cyc(2); btn_start = 1'b0; cyc(3);
   endtask

   int ts_s = 0, ts_h = 0, a0;

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cst", 8'(cst), 8'd0);
      chk("rst_dzst", 8'(dzst), 8'd0);
      chk("rst_num", 8'(num), 8'd1);
      chk("rst_score", 8'(score), 8'd0);
      chk_en = 1'b1;
      rst = 1'b0;
      cyc(2);

      // first round: countdown 3, lost on timeout
      sw_num = 3'd3; a0 = arm_low;
      btn_start = 1'b1; cyc(25); btn_start = 1'b0; cyc(5);
      chk("r1_arm_cycles", 8'(arm_low - a0), 8'd2);
      chk("r1_num", 8'(num), 8'd3);
      chk("r1_cst_run", 8'(cst), 8'd1);
      over = 1'b1; cyc(2);
      chk("r1_lose", 8'(lose), 8'd1);
      chk("r1_round", 8'(round_no), 8'd1);
      chk("r1_score", 8'(score), 8'd0);
      over = 1'b0;

      // second round: short glitch ignored, long hit wins, hit in RESULT ignored
      press_start(25); wait_run();
      press_hit(5); cyc(30);
      chk("glitch_cst", 8'(cst), 8'd1);
      chk("glitch_win", 8'(win), 8'd0);
      chk("glitch_round", 8'(round_no), 8'd1);
      press_hit(25);
      chk("r2_win", 8'(win), 8'd1);
      chk("r2_score", 8'(score), 8'd1);
      press_hit(25);
      chk("r2_extra_score", 8'(score), 8'd1);
      chk("r2_extra_round", 8'(round_no), 8'd2);

      // third round: hit pulse and over on the same edge
      press_start(25); wait_run();
      btn_hit = 1'b1; cyc(22); over = 1'b1; cyc(3); btn_hit = 1'b0;
      chk("tie_lose", 8'(lose), 8'd1);
      chk("tie_win", 8'(win), 8'd0);
      chk("tie_score", 8'(score), 8'd1);
      over = 1'b0; cyc(2);

      // finish this game, then a full five-win game
      win_round(); win_round(); cyc(3);
      chk("g1_done", 8'(game_done), 8'd1);
      chk("g1_round", 8'(round_no), 8'd5);
      chk("g1_score", 8'(score), 8'd3);
      sw_num = 3'd0;
      start_check();
      chk("sw0_num", 8'(num), 8'd1);
      wait_run(); press_hit(25);
      for (int r = 0; r < 4; r++) win_round();
      cyc(3);
      chk("g2_score", 8'(score), 8'd5);
      chk("g2_round", 8'(round_no), 8'd5);
      chk("g2_done", 8'(game_done), 8'd1);
      sw_num = 3'd6;
      start_check();
      chk("g3_num", 8'(num), 8'd6);

      // reset while counting down
      wait_run(); press_hit(25);
      press_start(25); wait_run();
      rst = 1'b1; @(negedge clk);
      chk("midrst_cst", 8'(cst), 8'd0);
      chk("midrst_dzst", 8'(dzst), 8'd0);
      chk("midrst_score", 8'(score), 8'd0);
      chk("midrst_num", 8'(num), 8'd1);
      rst = 1'b0; cyc(2);

      // random traffic
      for (int c = 0; c < 15000; c++) begin
         if (ts_s == 0) begin
            btn_start = !btn_start;
            ts_s = btn_start ? int'($urandom_range(40, 1)) : int'($urandom_range(60, 1));
         end else ts_s--;
         if (ts_h == 0) begin
            btn_hit = !btn_hit;
            ts_h = btn_hit ? int'($urandom_range(40, 1)) : int'($urandom_range(50, 1));
         end else ts_h--;
         if (over) begin
            if ($urandom_range(9, 0) == 0) over = 1'b0;
         end else if ($urandom_range(29, 0) == 0) over = 1'b1;
         if ($urandom_range(99, 0) == 0) sw_num = 3'($urandom_range(7, 0));
         rst = ($urandom_range(999, 0) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
